core_padio: RTL and testbench

- Bus responder for the controller I/O registers $4016/$4017 on the core's external bus, i.e. the responder end of the CPU bus interface.
- Latches OUT[2:0] on writes to $4016.
- Drives per-port read-enable strobes.
- Returns serial controller data on reads.
- Optionally emulates two standard 8-button pads internally with shift registers.

---
 rtl/core_io_pkg.sv | 37 +++
 rtl/core_pad_shift.sv | 34 +++
 rtl/core_padio.sv | 124 ++++++++++++
 tb/tb_core_padio.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_io_pkg.sv
// Shared constants and types for the controller I/O register block.
package core_io_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OUT_W   = 3;
  localparam int unsigned PORTS   = 2;
  localparam int unsigned EXT_W   = 4;
  localparam int unsigned BTN_W   = 8;
  localparam int unsigned OBUS_W  = 3;

  localparam logic [ADDR_W-1:0] ADDR_JOY1 = 16'h4016;
  localparam logic [ADDR_W-1:0] ADDR_JOY2 = 16'h4017;

  // Bit positions of each button within a pad report (serial order A first).
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Standard pad report, bit 0 = A .. bit 7 = Right, 1 = pressed.
  typedef struct packed {
    logic right;
    logic left;
    logic down;
    logic up;
    logic start;
    logic select;
    logic b;
    logic a;
  } pad_buttons_t;

endpackage

// File: rtl/core_pad_shift.sv
// Emulated standard pad: parallel-load while strobe is high, shift out
// one button per read pulse while strobe is low, then report 1 forever.
//   clk, rst_n : clock, async active-low reset (register resets to all ones)
//   strobe     : OUT[0] latch; reloads the buttons every clock while high
//   shift      : one-clock pulse advancing the serial stream
//   buttons    : live button state
//   d0         : current serial bit (bit 0 of the register)
module core_pad_shift
  import core_io_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic         shift,
  input  pad_buttons_t buttons,
  output logic         d0
);

  logic [BTN_W-1:0] shreg;

  // Ones shift in from the top so an exhausted report reads as 1, no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '1;
    end else if (strobe) begin
      shreg <= BTN_W'(buttons);
    end else if (shift) begin
      shreg <= {1'b1, shreg[BTN_W-1:1]};
    end
  end

  assign d0 = shreg[0];

endmodule

// File: rtl/core_padio.sv
// Responder for the controller registers $4016/$4017 on the core bus.
// Write $4016 latches OUT[2:0]; reads return {open bus, D4..D1, D0} and
// pulse the per-port read strobe. Response is registered one clock after
// the phy2 rising edge and held until the clock after phy2 falls.
//   I_clock, I_reset        : clock, async active-low reset
//   I_addr, I_wr_data,
//   I_rdwr, I_phy2          : core bus request (I_rdwr 1 = read)
//   O_rd_data, O_hit        : read data and bus-claim indication
//   O_out, O_oe             : OUT latch and per-port read strobes
//   I_ser, I_ext            : external serial D0 and D1..D4 lines
//   I_buttons0, I_buttons1  : buttons for the internal pads
module core_padio
  import core_io_pkg::*;
#(
  parameter bit                INTERNAL_PAD = 1'b1,
  parameter logic [OBUS_W-1:0] OPEN_BUS_HI  = 3'b010
) (
  input  logic               I_clock,
  input  logic               I_reset,
  input  logic [ADDR_W-1:0]  I_addr,
  input  logic [DATA_W-1:0]  I_wr_data,
  input  logic               I_rdwr,
  input  logic               I_phy2,
  output logic [DATA_W-1:0]  O_rd_data,
  output logic               O_hit,
  output logic [OUT_W-1:0]   O_out,
  output logic [PORTS-1:0]   O_oe,
  input  logic [PORTS-1:0]   I_ser,
  input  logic [2*EXT_W-1:0] I_ext,
  input  logic [BTN_W-1:0]   I_buttons0,
  input  logic [BTN_W-1:0]   I_buttons1
);

  logic              phy2_q;
  logic              access_edge_c;
  logic              sel_joy1_c;
  logic              sel_joy2_c;
  logic              wr_joy1_c;
  logic              load_next_c;
  logic [PORTS-1:0]  rd_c;
  logic [PORTS-1:0]  shift_c;
  logic [PORTS-1:0]  d0_c;
  logic [EXT_W-1:0]  ext_nib_c;
  logic              d0_sel_c;
  logic [DATA_W-1:0] rd_word_c;

  // Access happens once per bus cycle, on the first clock phy2 is seen high.
  assign access_edge_c = I_phy2 & ~phy2_q;
  assign sel_joy1_c    = (I_addr == ADDR_JOY1);
  assign sel_joy2_c    = (I_addr == ADDR_JOY2);

  // $4017 writes belong to the frame counter, so only $4016 writes land here.
  assign wr_joy1_c   = access_edge_c & ~I_rdwr & sel_joy1_c;
  assign rd_c        = {access_edge_c & I_rdwr & sel_joy2_c,
                        access_edge_c & I_rdwr & sel_joy1_c};
  assign load_next_c = wr_joy1_c & I_wr_data[0];

  // No shift while strobing; a strobe being raised on the same edge wins.
  assign shift_c = rd_c & {PORTS{~O_out[0] & ~load_next_c}};

  generate
    if (INTERNAL_PAD) begin : g_pad
      logic unused_ser;
      assign unused_ser = ^I_ser;

      core_pad_shift u_pad0 (
        .clk     (I_clock),
        .rst_n   (I_reset),
        .strobe  (O_out[0]),
        .shift   (shift_c[0]),
        .buttons (pad_buttons_t'(I_buttons0)),
        .d0      (d0_c[0])
      );

      core_pad_shift u_pad1 (
        .clk     (I_clock),
        .rst_n   (I_reset),
        .strobe  (O_out[0]),
        .shift   (shift_c[1]),
        .buttons (pad_buttons_t'(I_buttons1)),
        .d0      (d0_c[1])
      );
    end else begin : g_ext
      logic unused_pad;
      assign unused_pad = ^{I_buttons0, I_buttons1, shift_c};
      assign d0_c       = I_ser;
    end
  endgenerate

  // Read data mux: port is fixed by the exact address match.
  assign ext_nib_c = sel_joy2_c ? I_ext[2*EXT_W-1:EXT_W] : I_ext[EXT_W-1:0];
  assign d0_sel_c  = sel_joy2_c ? d0_c[1] : d0_c[0];
  assign rd_word_c = {OPEN_BUS_HI, ext_nib_c, d0_sel_c};

  logic unused_wr;
  assign unused_wr = ^I_wr_data[DATA_W-1:OUT_W];

  // Bus response registers; claim set at the access edge, cleared once phy2 is low.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      phy2_q    <= 1'b1;
      O_out     <= '0;
      O_hit     <= 1'b0;
      O_oe      <= '0;
      O_rd_data <= '0;
    end else begin
      phy2_q <= I_phy2;
      if (wr_joy1_c) begin
        O_out <= I_wr_data[OUT_W-1:0];
      end
      if (wr_joy1_c || (|rd_c)) begin
        O_hit <= 1'b1;
        O_oe  <= rd_c;
      end else if (!I_phy2) begin
        O_hit <= 1'b0;
        O_oe  <= '0;
      end
      if (|rd_c) begin
        O_rd_data <= rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_core_padio.sv
// Bench for core_padio: directed steps followed by randomized bus traffic,
// checked against a read-counter model of the pads. Two instances cover the
// internal-pad and external-serial configurations side by side.
module tb_core_padio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        rdwr;
  logic        phy2;
  logic [1:0]  ser;
  logic [7:0]  ext;
  logic [7:0]  buttons0;
  logic [7:0]  buttons1;

  logic [7:0]  rd_data_i, rd_data_e;
  logic        hit_i, hit_e;
  logic [2:0]  out_i, out_e;
  logic [1:0]  oe_i, oe_e;

  int errors = 0;
  int checks = 0;

  // Reference model: OUT latch, per-pad captured report and reads consumed.
  logic [2:0] m_out;
  logic [7:0] m_latched [2];
  int         m_idx [2];
  logic [7:0] exp_rd_i;
  logic [7:0] exp_rd_e;

  always #5 clk = ~clk;

  core_padio #(.INTERNAL_PAD(1'b1), .OPEN_BUS_HI(3'b010)) dut_int (
    .I_clock(clk), .I_reset(rst_n), .I_addr(addr), .I_wr_data(wr_data),
    .I_rdwr(rdwr), .I_phy2(phy2), .O_rd_data(rd_data_i), .O_hit(hit_i),
    .O_out(out_i), .O_oe(oe_i), .I_ser(ser), .I_ext(ext),
    .I_buttons0(buttons0), .I_buttons1(buttons1)
  );

  core_padio #(.INTERNAL_PAD(1'b0), .OPEN_BUS_HI(3'b010)) dut_ext (
    .I_clock(clk), .I_reset(rst_n), .I_addr(addr), .I_wr_data(wr_data),
    .I_rdwr(rdwr), .I_phy2(phy2), .O_rd_data(rd_data_e), .O_hit(hit_e),
    .O_out(out_e), .O_oe(oe_e), .I_ser(ser), .I_ext(ext),
    .I_buttons0(buttons0), .I_buttons1(buttons1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] btn(input int p);
    return (p == 1) ? buttons1 : buttons0;
  endfunction

  function automatic logic [3:0] nib(input int p);
    return (p == 1) ? ext[7:4] : ext[3:0];
  endfunction

  // Serial bit a pad presents: live A while strobing, else the n-th captured
  // button, and 1 once all eight have been read.
  function automatic logic model_d0(input int p);
    logic [7:0] b;
    if (m_out[0]) begin
      b = btn(p);
      return b[0];
    end
    b = m_latched[p];
    return (m_idx[p] < 8) ? b[m_idx[p]] : 1'b1;
  endfunction

  task automatic model_reset();
    m_out = 3'b000;
    for (int p = 0; p < 2; p++) begin
      m_latched[p] = 8'hFF;
      m_idx[p]     = 0;
    end
    exp_rd_i = 8'h00;
    exp_rd_e = 8'h00;
  endtask

  // One complete bus cycle: phy2 low one clock, high two clocks, then low.
  task automatic bus_cycle(input logic [15:0] a, input logic rd, input logic [7:0] wd,
                           output logic [7:0] obs_i, output logic [7:0] obs_e);
    logic       is_rd, is_wr, e_hit;
    logic [1:0] e_oe;
    int         p;
    is_rd = rd && (a == 16'h4016 || a == 16'h4017);
    is_wr = !rd && (a == 16'h4016);
    p     = (a == 16'h4017) ? 1 : 0;
    e_hit = is_rd || is_wr;
    e_oe  = 2'b00;
    if (is_rd) begin
      exp_rd_i = {3'b010, nib(p), model_d0(p)};
      exp_rd_e = {3'b010, nib(p), ser[p]};
      e_oe     = (p == 1) ? 2'b10 : 2'b01;
    end
    if (m_out[0]) begin
      for (int q = 0; q < 2; q++) begin
        m_latched[q] = btn(q);
        m_idx[q]     = 0;
      end
    end else if (is_rd && m_idx[p] < 8) begin
      m_idx[p]++;
    end
    if (is_wr) begin
      m_out = wd[2:0];
      if (m_out[0]) begin
        for (int q = 0; q < 2; q++) begin
          m_latched[q] = btn(q);
          m_idx[q]     = 0;
        end
      end
    end

    @(posedge clk); #1;
    addr = a; rdwr = rd; wr_data = wd; phy2 = 1'b0;
    @(posedge clk); #1;
    phy2 = 1'b1;
    @(posedge clk); #1;
    chk("hit_int", 16'(hit_i), 16'(e_hit));
    chk("hit_ext", 16'(hit_e), 16'(e_hit));
    chk("oe_int", 16'(oe_i), 16'(e_oe));
    chk("oe_ext", 16'(oe_e), 16'(e_oe));
    chk("rd_int", 16'(rd_data_i), 16'(exp_rd_i));
    chk("rd_ext", 16'(rd_data_e), 16'(exp_rd_e));
    chk("out_int", 16'(out_i), 16'(m_out));
    chk("out_ext", 16'(out_e), 16'(m_out));
    obs_i = rd_data_i;
    obs_e = rd_data_e;
    @(posedge clk); #1;
    chk("hit_hold", 16'(hit_i), 16'(e_hit));
    chk("oe_hold", 16'(oe_i), 16'(e_oe));
    phy2 = 1'b0;
    @(posedge clk); #1;
    chk("hit_clear", 16'({hit_i, hit_e}), 16'(2'b00));
    chk("oe_clear", 16'({oe_i, oe_e}), 16'(4'b0000));
    chk("rd_keep_int", 16'(rd_data_i), 16'(exp_rd_i));
    chk("rd_keep_ext", 16'(rd_data_e), 16'(exp_rd_e));
  endtask

  initial begin
    logic [7:0]  ri, re, wd;
    logic [9:0]  seq;
    logic [15:0] a;
    int          sel;

    rst_n = 1'b0; addr = 16'h0000; wr_data = 8'h00; rdwr = 1'b1; phy2 = 1'b0;
    ser = 2'b00; ext = 8'h00; buttons0 = 8'h00; buttons1 = 8'h00;
    model_reset();

    // Reset state, then release with phy2 already high: no access edge.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 16'({out_i, out_e}), 16'(6'b0));
    chk("rst_hit", 16'({hit_i, hit_e}), 16'(2'b0));
    chk("rst_oe", 16'({oe_i, oe_e}), 16'(4'b0));
    chk("rst_rd", 16'({rd_data_i, rd_data_e}), 16'h0000);
    addr = 16'h4016; rdwr = 1'b1; phy2 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_hit_after_rst", 16'({hit_i, hit_e, oe_i, oe_e}), 16'h0000);
    end
    phy2 = 1'b0;
    @(posedge clk); #1;

    // OUT latch writes; $4017 and $4015 writes leave it alone.
    bus_cycle(16'h4016, 1'b0, 8'h05, ri, re);
    chk("out_101", 16'(out_i), 16'(3'b101));
    bus_cycle(16'h4016, 1'b0, 8'h00, ri, re);
    chk("out_000", 16'(out_i), 16'(3'b000));
    bus_cycle(16'h4016, 1'b0, 8'h07, ri, re);
    bus_cycle(16'h4017, 1'b0, 8'h00, ri, re);
    bus_cycle(16'h4015, 1'b0, 8'h00, ri, re);
    chk("out_unchanged", 16'(out_i), 16'(3'b111));
    bus_cycle(16'h4016, 1'b0, 8'h00, ri, re);

    // Pad 0 report A5, ten reads: eight buttons then ones.
    buttons0 = 8'b1010_0101;
    bus_cycle(16'h4016, 1'b0, 8'h01, ri, re);
    bus_cycle(16'h4016, 1'b0, 8'h00, ri, re);
    seq = 10'b11_1010_0101;
    for (int k = 0; k < 10; k++) begin
      bus_cycle(16'h4016, 1'b1, 8'h00, ri, re);
      chk("pad0_d0_seq", 16'(ri[0]), 16'(seq[k]));
      chk("pad0_openbus", 16'(ri[7:5]), 16'(3'b010));
    end

    // Pad 1 while strobing returns live A; after strobe drops 1,0,0.
    buttons1 = 8'h01;
    bus_cycle(16'h4016, 1'b0, 8'h01, ri, re);
    for (int k = 0; k < 3; k++) begin
      bus_cycle(16'h4017, 1'b1, 8'h00, ri, re);
      chk("pad1_strobe_d0", 16'(ri[0]), 16'(1'b1));
    end
    bus_cycle(16'h4016, 1'b0, 8'h00, ri, re);
    seq = 10'b00_0000_0001;
    for (int k = 0; k < 3; k++) begin
      bus_cycle(16'h4017, 1'b1, 8'h00, ri, re);
      chk("pad1_d0_seq", 16'(ri[0]), 16'(seq[k]));
    end

    // External serial configuration.
    ser = 2'b10; ext = 8'hA3;
    bus_cycle(16'h4016, 1'b1, 8'h00, ri, re);
    chk("ext_rd_4016", 16'(re), 16'(8'b010_0011_0));
    bus_cycle(16'h4017, 1'b1, 8'h00, ri, re);
    chk("ext_rd_4017", 16'(re), 16'(8'b010_1010_1));

    // Randomized bus traffic.
    for (int i = 0; i < 300; i++) begin
      buttons0 = 8'($urandom);
      buttons1 = 8'($urandom);
      ser      = 2'($urandom);
      ext      = 8'($urandom);
      sel      = int'($urandom_range(0, 9));
      if (sel <= 2) begin
        wd    = 8'($urandom);
        wd[0] = ($urandom_range(0, 3) == 0);
        bus_cycle(16'h4016, 1'b0, wd, ri, re);
      end else if (sel <= 7) begin
        a = ($urandom_range(0, 1) == 1) ? 16'h4017 : 16'h4016;
        bus_cycle(a, 1'b1, 8'h00, ri, re);
      end else if (sel == 8) begin
        bus_cycle(16'h4017, 1'b0, 8'($urandom), ri, re);
      end else begin
        a = 16'($urandom);
        if (a == 16'h4016 || a == 16'h4017) a = 16'h4015;
        bus_cycle(a, 1'($urandom), 8'($urandom), ri, re);
      end
    end

    // Reset during phy2 high of a $4016 read.
    buttons0 = 8'h00;
    bus_cycle(16'h4016, 1'b0, 8'h01, ri, re);
    bus_cycle(16'h4016, 1'b0, 8'h00, ri, re);
    bus_cycle(16'h4016, 1'b1, 8'h00, ri, re);
    chk("pre_rst_d0", 16'(ri[0]), 16'(1'b0));
    @(posedge clk); #1;
    addr = 16'h4016; rdwr = 1'b1; phy2 = 1'b0;
    @(posedge clk); #1;
    phy2 = 1'b1;
    @(posedge clk); #1;
    chk("mid_hit_set", 16'({hit_i, oe_i}), 16'(3'b101));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hit", 16'({hit_i, hit_e}), 16'(2'b00));
    chk("mid_rst_oe", 16'({oe_i, oe_e}), 16'(4'b0000));
    chk("mid_rst_rd", 16'(rd_data_i), 16'h0000);
    model_reset();
    phy2 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_cycle(16'h4016, 1'b1, 8'h00, ri, re);
    chk("post_rst_d0", 16'(ri[0]), 16'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
